// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, radix-2 shift-add multiply and restoring divide,
// one-cycle register-file write pulse on completion.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int RD_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    input  logic [RD_WIDTH-1:0] rd_in,
    output logic                busy,
    output logic                done,
    output logic                we,
    output logic [RD_WIDTH-1:0] rd_out,
    output logic [XLEN-1:0]     result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d, m_q, m_d, result_q, result_d;
    logic [2:0]            f_q, f_d;
    logic                  neg_q, neg_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;

    logic                  a_neg, b_neg, div_zero, div_ovf, ge;
    logic [XLEN-1:0]       a_mag, b_mag, step_hi, step_lo, qr, fin;
    logic [XLEN:0]         sum, rem_t, diff;
    logic [2*XLEN-1:0]     prod;

    // Signed-ness per op: MULH both, MULHSU rs1 only, DIV/REM both.
    assign a_neg    = op_a[XLEN-1] & (funct3[2] ? !funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010));
    assign b_neg    = op_b[XLEN-1] & (funct3[2] ? !funct3[0] : (funct3 == 3'b001));
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    assign div_zero = op_b == '0;
    assign div_ovf  = !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;

    // hi holds the accumulator/partial remainder, lo the multiplier/dividend shifting into the quotient.
    assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign rem_t   = {hi_q, lo_q[XLEN-1]};
    assign diff    = rem_t - {1'b0, m_q};
    assign ge      = !diff[XLEN];
    assign step_hi = f_q[2] ? (ge ? diff[XLEN-1:0] : rem_t[XLEN-1:0]) : sum[XLEN:1];
    assign step_lo = f_q[2] ? {lo_q[XLEN-2:0], ge} : {sum[0], lo_q[XLEN-1:1]};
    assign prod    = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign qr      = f_q[1] ? step_hi : step_lo;
    assign fin     = f_q[2] ? (neg_q ? -qr : qr)
                            : (f_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        neg_d    = neg_q;
        f_d      = f_q;
        rd_d     = rd_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                f_d   = funct3;
                rd_d  = rd_in;
                cnt_d = '0;
                hi_d  = '0;
                lo_d  = funct3[2] ? a_mag : b_mag;
                m_d   = funct3[2] ? b_mag : a_mag;
                neg_d = (funct3[2] && funct3[1]) ? a_neg : a_neg ^ b_neg;
                state_d = RUN;
                if (funct3[2] && div_zero) begin
                    result_d = funct3[1] ? op_a : '1;
                    state_d  = DONE;
                end else if (funct3[2] && div_ovf) begin
                    result_d = funct3[1] ? '0 : op_a;
                    state_d  = DONE;
                end
            end
            RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    result_d = fin;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            f_q      <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            f_q      <= f_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign we     = done && rd_q != '0;
    assign rd_out = rd_q;
    assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random RV32M operations checked against a plain-arithmetic model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, we;
    logic [4:0]  rd_out;
    logic [31:0] result;
    int tests = 0, fails = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .rd_in(rd_in), .busy(busy), .done(done), .we(we), .rd_out(rd_out), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        bit ovf;
        sa  = a;
        sb  = b;
        ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (f)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5:    return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6:    return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    // Called #1 after a rising edge with the unit idle; scrambles inputs while busy.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_r);
        int  n;
        bit  sp;
        sp = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_accept", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            start = 1'($urandom_range(0, 1));
            op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom); funct3 = 3'($urandom);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk($sformatf("latency f%0d", f), 64'(n), sp ? 0 : 32);
        chk($sformatf("result f%0d %h %h", f, a, b), result, exp_r);
        chk("busy_in_done", busy, 1);
        chk("we", we, rd != 0);
        chk("rd_out", rd_out, rd);
        @(posedge clk); #1;
        chk("done_pulse_end", {busy, done, we}, 0);
        chk("result_held", result, exp_r);
    endtask

    initial begin
        #3;
        chk("reset_outputs", {busy, done, we, rd_out, result}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", {busy, done}, 0);

        run_op(3'd0, 32'd7, -32'sd3, 5'd5, 32'hFFFF_FFEB);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0);
        run_op(3'd4, -32'sd20, 32'd3, 5'd3, 32'hFFFF_FFFA);
        run_op(3'd6, -32'sd20, 32'd3, 5'd4, 32'hFFFF_FFFE);
        run_op(3'd5, 32'd20, 32'd3, 5'd6, 32'd6);
        run_op(3'd5, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd5, 32'd0, 5'd8, 32'd5);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);

        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, we, rd_out, result}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(3'd0, 32'd2, 32'd3, 5'd12, 32'd6);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(f, a, b, 5'($urandom), ref_model(f, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
